// File: rtl/immediate_formatter_if.sv
// Request and character-stream handshake bundle for the immediate formatter.
// The master side issues format requests and consumes characters; the slave side is the formatter.
interface immediate_formatter_if;
  logic        start;
  logic [31:0] immediate;
  logic        term_sel;
  logic        start_ready;
  logic [7:0]  ascii_out;
  logic        ascii_valid;
  logic        ascii_ready;

  modport master (
    output start, immediate, term_sel, ascii_ready,
    input  start_ready, ascii_out, ascii_valid
  );

  modport slave (
    input  start, immediate, term_sel, ascii_ready,
    output start_ready, ascii_out, ascii_valid
  );
endinterface

// File: rtl/immediate_formatter.sv
// Emits a 32-bit immediate as an ASCII token "x<hex digits><terminator>", one character per handshake.
// First character one cycle after accept; a stalled ascii_ready simply holds the current character.
module immediate_formatter #(
  parameter int UPPERCASE      = 1,
  parameter int SUPPRESS_ZEROS = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  immediate_formatter_if.slave  bus,
  output logic                  busy_flag,
  output logic                  done_flag
);

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    DIGITS,
    TERM,
    DONE
  } state_t;

  localparam logic [7:0] CHAR_X     = 8'h78;
  localparam logic [7:0] CHAR_COMMA = 8'h2C;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  ndig_q, ndig_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        term_q, term_d;
  logic [3:0]  nibble;
  logic [7:0]  out_c;
  logic        valid_c;
  logic        start_ready_c;
  logic        busy_c;
  logic        done_c;

  // Highest non-zero nibble index plus one; a zero value still yields one digit.
  function automatic logic [3:0] count_digits(input logic [31:0] v);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) n = 4'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
    else             c = ALPHA_BASE + {4'h0, nib} - 8'd10;
    return c;
  endfunction

  assign nibble = value_q[{cnt_q, 2'b00} +: 4];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      value_q <= '0;
      ndig_q  <= '0;
      cnt_q   <= '0;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      ndig_q  <= ndig_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
    end
  end

  // Outputs depend only on registered state; ascii_ready steers next state only.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    ndig_d        = ndig_q;
    cnt_d         = cnt_q;
    term_d        = term_q;
    out_c         = 8'h00;
    valid_c       = 1'b0;
    start_ready_c = 1'b0;
    busy_c        = 1'b1;
    done_c        = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready_c = 1'b1;
        busy_c        = 1'b0;
        if (bus.start) begin
          value_d = bus.immediate;
          term_d  = bus.term_sel;
          ndig_d  = (SUPPRESS_ZEROS != 0) ? count_digits(bus.immediate) : 4'd8;
          state_d = PREFIX;
        end
      end
      PREFIX: begin
        valid_c = 1'b1;
        out_c   = CHAR_X;
        if (bus.ascii_ready) begin
          cnt_d   = 3'(ndig_q - 4'd1);
          state_d = DIGITS;
        end
      end
      DIGITS: begin
        valid_c = 1'b1;
        out_c   = hex_char(nibble);
        if (bus.ascii_ready) begin
          if (cnt_q == 3'd0) state_d = TERM;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      TERM: begin
        valid_c = 1'b1;
        out_c   = term_q ? CHAR_SPACE : CHAR_COMMA;
        if (bus.ascii_ready) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ascii_out   = out_c;
  assign bus.ascii_valid = valid_c;
  assign bus.start_ready = start_ready_c;
  assign busy_flag       = busy_c;
  assign done_flag       = done_c;

endmodule

// File: doc/immediate_formatter.md
# immediate_formatter

Converts a 32-bit immediate into the ASCII hex token format the assembler front end parses: an `x` prefix, hex digits MSB-first with leading zeros suppressed, then a one-character terminator. It is the emit side of the immediate token path. It feeds disassembly, listing and UART echo paths, one character per handshake. Its output must round-trip through the assembler's immediate parser.

## Interface
Parameters:
- `UPPERCASE`, default 1: 1 emits `A`–`F`; 0 emits `a`–`f`.
- `SUPPRESS_ZEROS`, default 1: 1 drops leading zero digits; 0 always emits 8 digits.

Ports:
- `clk_in`, input, 1: the only clock.
- `rst_in`, input, 1: synchronous, active-low reset, sampled on `posedge clk_in`.
- `start`, input, 1: request to format `immediate`. Accepted only when `start_ready` is 1.
- `immediate`, input, 32: value to format. Sampled only on the accept cycle.
- `term_sel`, input, 1: terminator choice, 0 = `,` (0x2C), 1 = space (0x20). Sampled on the accept cycle.
- `start_ready`, output, 1: high exactly when the FSM is in IDLE.
- `ascii_out`, output, 8: current character.
- `ascii_valid`, output, 1: `ascii_out` is presented.
- `ascii_ready`, input, 1: downstream accepts the character. A transfer occurs when `ascii_valid` and `ascii_ready` are both 1 on a rising edge.
- `busy_flag`, output, 1: FSM is not in IDLE.
- `done_flag`, output, 1: one-cycle pulse after the terminator transfers.

## Operation
- States: IDLE, PREFIX, DIGITS, TERM, DONE.
- **IDLE**
  - On `start`, latch `immediate` into `value_q` and latch `term_sel`.
  - Latch `ndig_q`. With `SUPPRESS_ZEROS`=1, `ndig_q` is the index of the highest non-zero nibble plus 1, and 1 for a value of 0, so the range is 1..8. With `SUPPRESS_ZEROS`=0, `ndig_q` is 8.
  - Go to PREFIX.
- **PREFIX**: `ascii_out`=`x` (0x78) with valid high. On transfer, go to DIGITS with the digit counter set to `ndig_q`-1.
- **DIGITS**
  - `ascii_out` is the ASCII form of nibble `value_q[4*cnt+3 : 4*cnt]`: `0`–`9` map to 0x30–0x39, and 10–15 map to 0x41–0x46 (or 0x61–0x66 when `UPPERCASE`=0).
  - On transfer: if `cnt`==0, go to TERM; otherwise decrement `cnt`.
- **TERM**: `ascii_out` is the latched terminator. On transfer, go to DONE.
- **DONE**: `done_flag`=1 and `ascii_valid`=0 for exactly one cycle, then IDLE.
- Outputs:
  - `ascii_valid` is 1 in PREFIX, DIGITS and TERM only.
  - `ascii_out` is 0x00 whenever `ascii_valid` is 0.
  - `ascii_out` is held stable while `ascii_valid` is 1 and `ascii_ready` is 0. No character is ever dropped or repeated.
- `start` outside IDLE is ignored. The in-flight token is unaffected, and inputs are not re-latched.
- `immediate` and `term_sel` may change freely after the accept cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `ascii_ready` to `ascii_out`.
- Reset (`rst_in`=0 on an edge) forces IDLE regardless of state, including mid-token. The partial token is abandoned and no `done_flag` is raised.
- Reset values: `start_ready`=1, `busy_flag`=0, `ascii_valid`=0, `ascii_out`=0x00, `done_flag`=0. `value_q`, `ndig_q` and `cnt` are cleared to 0.

## Timing
- Accept at edge 0, so the first character (`x`) is valid in cycle 1. There is no bubble between consecutive characters of a token.
- With `ascii_ready` held at 1, a token of N digits has N+2 transfers on edges 1..N+2. `done_flag` is high in cycle N+3, and `start_ready` returns in cycle N+4.
- Best case, 1 digit: 3 characters, done in cycle 4. Worst case, 8 digits: 10 characters, done in cycle 11.
- Each cycle with `ascii_ready`=0 while valid extends the token by exactly one cycle.
- `start` asserted during DONE is ignored. It must be reasserted once `start_ready` is 1.

## Test plan
- `immediate`=0x000000A5, `term_sel`=0, ready always 1 → stream 0x78 0x41 0x35 0x2C on cycles 1–4, `done_flag` in cycle 5, `start_ready` in cycle 6.
- `immediate`=0x00000000, `term_sel`=1 → `x0 ` (0x78 0x30 0x20), then `done_flag`. A second build with `SUPPRESS_ZEROS`=0 → `x00000000 `.
- `immediate`=0xFFFFFFFF; rebuild with `UPPERCASE`=0 and `immediate`=0xDEADBEEF → `xFFFFFFFF,` (10 transfers, done in cycle 11), then `xdeadbeef,`.
- `immediate`=0x1234, random `ascii_ready` stalls of 1–5 cycles → `ascii_out` is stable across every stall and the captured stream is exactly `x1234,`. Additionally, pulse `start` with 0x99 mid-token → ignored, and the stream is unchanged.
- `immediate`=0x12345678, assert `rst_in`=0 on the edge after the third digit transfers → next cycle `ascii_valid`=0, `busy_flag`=0, no `done_flag`. A following start with 0x7 → clean `x7,`.
- Round trip: random 32-bit values → the emitted stream is fed into the assembler immediate parser, and the recovered value matches the original for every value.
